keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, one column at a time, and reports the currently held key as a one-hot row/column code.
- Drives one-hot column strobes and reads back four active-high row lines.
- Resolves each full sweep to zero or one key, debounces across sweeps, and exposes a stable keycode with a valid flag.
- Sits between the keypad pins and the input-handling logic.

---
 rtl/keypad_scanner.sv | 159 +++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with sweep resolution and debounce (optional KEYPAD_SYNC_EN row synchronizer)
module keypad_scanner #(
  parameter int SCAN_DIV        = 1,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] readrow,
  output logic [3:0] scancol,
  output logic [7:0] keycode,
  output logic       keyvalid
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_MAX  = 8'(DEBOUNCE_SWEEPS);

  logic [15:0] dwell;
  logic        dwell_last;
  logic [3:0]  smp_row;
  logic [3:0]  smp_col;
  logic        smp_en;
  logic        sweep_ok;

  assign dwell_last = (dwell == DIV_LAST);

  // Column dwell counter and one-hot left rotation of the column strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell   <= '0;
      scancol <= 4'b0001;
    end else if (dwell_last) begin
      dwell   <= '0;
      scancol <= {scancol[2:0], scancol[3]};
    end else begin
      dwell <= dwell + 16'd1;
    end
  end

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_m;
  logic [3:0] row_s;
  logic [3:0] col_d1;
  logic [3:0] col_d2;
  logic [1:0] smp_d;

  // Two-flop row synchronizer; column tag and sample strobe delayed to stay aligned with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_m  <= '0;
      row_s  <= '0;
      col_d1 <= '0;
      col_d2 <= '0;
      smp_d  <= '0;
    end else begin
      row_m  <= readrow;
      row_s  <= row_m;
      col_d1 <= scancol;
      col_d2 <= col_d1;
      smp_d  <= {smp_d[0], dwell_last};
    end
  end

  // First sweep after reset straddles the pipeline fill, so its result is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      sweep_ok <= 1'b0;
    end else if (smp_en && smp_col[3]) begin
      sweep_ok <= 1'b1;
    end
  end

  assign smp_row = row_s;
  assign smp_col = col_d2;
  assign smp_en  = smp_d[1];
`else
  assign smp_row  = readrow;
  assign smp_col  = scancol;
  assign smp_en   = dwell_last;
  assign sweep_ok = 1'b1;
`endif

  logic       sweep_end;
  logic       col_hit;
  logic       col_amb;
  logic [7:0] acc_code;
  logic [1:0] acc_keys;
  logic       acc_amb;
  logic [7:0] nxt_code;
  logic [1:0] nxt_keys;
  logic       nxt_amb;
  logic [7:0] sweep_result;

  assign sweep_end = smp_en && smp_col[3];

  // Classify the sampled column and fold it into the running sweep totals
  always_comb begin
    col_hit  = (smp_row != 4'b0000) && $onehot(smp_row);
    col_amb  = (smp_row != 4'b0000) && !$onehot(smp_row);
    nxt_code = acc_code;
    nxt_keys = acc_keys;
    nxt_amb  = acc_amb | col_amb;
    if (col_hit) begin
      nxt_code = {smp_row, smp_col};
      if (acc_keys != 2'd2) begin
        nxt_keys = acc_keys + 2'd1;
      end
    end
    sweep_result = (nxt_keys == 2'd1 && !nxt_amb) ? nxt_code : 8'h00;
  end

  // Sweep accumulator; cleared once the last column has been folded in
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_code <= '0;
      acc_keys <= '0;
      acc_amb  <= 1'b0;
    end else if (smp_en) begin
      if (sweep_end) begin
        acc_code <= '0;
        acc_keys <= '0;
        acc_amb  <= 1'b0;
      end else begin
        acc_code <= nxt_code;
        acc_keys <= nxt_keys;
        acc_amb  <= nxt_amb;
      end
    end
  end

  logic [7:0] prev_result;
  logic [7:0] match_cnt;

  // Count consecutive identical sweep results, saturating at the debounce target
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_result <= '0;
      match_cnt   <= '0;
    end else if (sweep_end && sweep_ok) begin
      if (sweep_result == prev_result) begin
        match_cnt <= (match_cnt >= DEB_MAX) ? DEB_MAX : match_cnt + 8'd1;
      end else begin
        prev_result <= sweep_result;
        match_cnt   <= 8'd1;
      end
    end
  end

  // Publish a debounced result one edge after it becomes stable and differs
  always_ff @(posedge clk) begin
    if (!rst) begin
      keycode  <= '0;
      keyvalid <= 1'b0;
    end else if (match_cnt == DEB_MAX && prev_result != keycode) begin
      keycode  <= prev_result;
      keyvalid <= (prev_result != 8'h00);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  readrow;
  logic [3:0]  scancol;
  logic [7:0]  keycode;
  logic        keyvalid;
  logic [15:0] pressed = '0;
  int          tests = 0;
  int          fails = 0;

  keypad_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .readrow  (readrow),
    .scancol  (scancol),
    .keycode  (keycode),
    .keyvalid (keyvalid)
  );

  always #5 clk = ~clk;

  // Keypad model: pressed[r*4+c] shorts row r to column c
  always_comb begin
    readrow = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (scancol[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[r*4+c]) readrow[r] = 1'b1;
        end
      end
    end
  end

  task automatic sync_sweep();
    int n;
    n = 0;
    @(negedge clk);
    while (scancol !== 4'b0001 && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (scancol !== 4'b0001) begin
      fails++;
      $display("FAIL sync_sweep scancol=%b expected 0001", scancol);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (scancol !== 4'b0001 || keycode !== 8'h00 || keyvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state scancol=%b keycode=%h keyvalid=%b expected 0001/00/0", scancol, keycode, keyvalid);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (scancol !== exp_col[i]) begin
        fails++;
        $display("FAIL rotation step %0d scancol=%b expected %b", i, scancol, exp_col[i]);
      end
    end
  endtask

  task automatic test_single_key();
    int n;
    sync_sweep();
    pressed = 16'h0001 << (2*4+1);
    n = 0;
    while (keyvalid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 17 || keycode !== 8'b01000010) begin
      fails++;
      $display("FAIL single_press latency=%0d keycode=%b expected 17/01000010", n, keycode);
    end
    sync_sweep();
    pressed = '0;
    n = 0;
    while (keyvalid !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 17 || keycode !== 8'h00) begin
      fails++;
      $display("FAIL single_release latency=%0d keycode=%h expected 17/00", n, keycode);
    end
  endtask

  task automatic test_each_key();
    logic [3:0] rr;
    logic [3:0] cc;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rr = 4'b0001 << r;
        cc = 4'b0001 << c;
        sync_sweep();
        pressed = 16'h0001 << (r*4+c);
        repeat (20) @(negedge clk);
        tests++;
        if (keycode !== {rr, cc} || keyvalid !== 1'b1) begin
          fails++;
          $display("FAIL each_key r%0d c%0d keycode=%b keyvalid=%b expected %b/1", r, c, keycode, keyvalid, {rr, cc});
        end
        pressed = '0;
        repeat (20) @(negedge clk);
        tests++;
        if (keycode !== 8'h00 || keyvalid !== 1'b0) begin
          fails++;
          $display("FAIL each_key_release r%0d c%0d keycode=%h keyvalid=%b expected 00/0", r, c, keycode, keyvalid);
        end
      end
    end
  endtask

  task automatic test_multi_press();
    int bad;
    sync_sweep();
    pressed = (16'h0001 << 0) | (16'h0001 << (1*4+2));
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (keycode !== 8'h00 || keyvalid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL multi_press nonzero cycles=%0d last keycode=%h expected 0", bad, keycode);
    end
    pressed = '0;
    repeat (20) @(negedge clk);
    sync_sweep();
    pressed = (16'h0001 << (0*4+3)) | (16'h0001 << (1*4+3));
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (keycode !== 8'h00 || keyvalid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ambiguous_column nonzero cycles=%0d last keycode=%h expected 0", bad, keycode);
    end
    pressed = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    sync_sweep();
    for (int k = 0; k < 3; k++) begin
      pressed = 16'h0001 << 1;
      repeat (8) begin
        @(negedge clk);
        if (keycode !== 8'h00) bad++;
      end
      pressed = '0;
      repeat (4) begin
        @(negedge clk);
        if (keycode !== 8'h00) bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bounce nonzero cycles=%0d last keycode=%h expected 0", bad, keycode);
    end
    pressed = 16'h0001 << 1;
    repeat (20) @(negedge clk);
    tests++;
    if (keycode !== 8'b00010010 || keyvalid !== 1'b1) begin
      fails++;
      $display("FAIL bounce_settle keycode=%b keyvalid=%b expected 00010010/1", keycode, keyvalid);
    end
    pressed = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int early;
    sync_sweep();
    pressed = 16'h0001 << 15;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (scancol !== 4'b0001 || keycode !== 8'h00 || keyvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state scancol=%b keycode=%h keyvalid=%b expected 0001/00/0", scancol, keycode, keyvalid);
    end
    rst = 1'b1;
    early = 0;
    repeat (16) begin
      @(negedge clk);
      if (keyvalid !== 1'b0) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL mid_reset_restart early valid cycles=%0d expected 0", early);
    end
    @(negedge clk);
    tests++;
    if (keycode !== 8'b10001000 || keyvalid !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_detect keycode=%b keyvalid=%b expected 10001000/1", keycode, keyvalid);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (keycode !== 8'h00 || keyvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_clears_key keycode=%h keyvalid=%b expected 00/0", keycode, keyvalid);
    end
    rst = 1'b1;
    pressed = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_each_key();
    test_multi_press();
    test_bounce();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
